// File: rtl/sel_encode_seq.sv
// Select/encode unit: latches the IR, decodes Ra/Rb/Rc into one-hot register enables,
// sign-extends the C constant, and sequences load/store-multiple over an IR register mask.
//
// state  | meaning
// IDLE   | normal decode; accepts ir_load and seq_start
// ACTIVE | walking the mask, one enable per accepted step
// DONE   | one-cycle seq_done pulse, normal decode, then IDLE
module sel_encode_seq #(
  parameter int NREGS  = 16,
  parameter int RBITS  = 4,
  parameter int IR_W   = 32,
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15,
  parameter int C_W    = 19
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             ir_load,
  input  logic [IR_W-1:0]  ir_in,
  input  logic             gra,
  input  logic             grb,
  input  logic             grc,
  input  logic             rin_en,
  input  logic             rout_en,
  input  logic             ba_out,
  input  logic             seq_start,
  input  logic             seq_adv,
  output logic [IR_W-1:0]  ir_q,
  output logic [IR_W-1:0]  c_sext,
  output logic [RBITS-1:0] sel_idx,
  output logic             sel_conflict,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout,
  output logic             r0_zero,
  output logic             seq_busy,
  output logic             seq_done,
  output logic [RBITS:0]   seq_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IR_W-1:0]  ir_d;
  logic [NREGS-1:0] mask_q, mask_d;
  logic [RBITS:0]   seq_count_q, seq_count_d;
  logic [RBITS-1:0] low_idx;
  logic [RBITS-1:0] ra_idx, rb_idx, rc_idx;
  logic             any_sel;
  logic [NREGS-1:0] onehot;

  assign ra_idx    = ir_q[RA_LSB +: RBITS];
  assign rb_idx    = ir_q[RB_LSB +: RBITS];
  assign rc_idx    = ir_q[RC_LSB +: RBITS];
  assign any_sel   = gra | grb | grc;
  assign c_sext    = {{(IR_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};
  assign seq_count = seq_count_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      mask_q      <= '0;
      seq_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      mask_q      <= mask_d;
      seq_count_q <= seq_count_d;
    end
  end

  // Lowest set bit of the remaining mask is the current step.
  always_comb begin
    low_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = RBITS'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    mask_d      = mask_q;
    seq_count_d = seq_count_q;
    case (state_q)
      S_IDLE: begin
        if (ir_load) ir_d = ir_in;
        // Mask comes from the current ir_q, even if ir_load is also high.
        if (seq_start) begin
          mask_d      = ir_q[NREGS-1:0];
          seq_count_d = '0;
          state_d     = (ir_q[NREGS-1:0] != '0) ? S_ACTIVE : S_DONE;
        end
      end
      S_ACTIVE: begin
        if (seq_adv) begin
          mask_d      = mask_q & (mask_q - NREGS'(1));
          seq_count_d = seq_count_q + (RBITS+1)'(1);
          if (mask_d == '0) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_idx      = '0;
    sel_conflict = 1'b0;
    onehot       = '0;
    rin          = '0;
    rout         = '0;
    r0_zero      = 1'b0;
    seq_busy     = (state_q == S_ACTIVE);
    seq_done     = (state_q == S_DONE);
    if (state_q == S_ACTIVE) begin
      sel_idx = low_idx;
      onehot  = NREGS'(1) << low_idx;
      rin     = onehot & {NREGS{rin_en}};
      rout    = onehot & {NREGS{rout_en}};
    end else begin
      if (gra)      sel_idx = ra_idx;
      else if (grb) sel_idx = rb_idx;
      else if (grc) sel_idx = rc_idx;
      sel_conflict = (gra & grb) | (gra & grc) | (grb & grc);
      if (any_sel) onehot = NREGS'(1) << sel_idx;
      rin  = onehot & {NREGS{rin_en}};
      rout = onehot & {NREGS{rout_en | ba_out}};
      if (ba_out && any_sel && (sel_idx == '0)) begin
        rout[0] = 1'b0;
        r0_zero = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sel_encode_seq.sv
// Self-checking bench for sel_encode_seq: directed scenarios plus randomized
// decode and sequencer runs checked against a field-level reference model.
module tb_sel_encode_seq;

  localparam int NREGS = 16;
  localparam int RBITS = 4;
  localparam int IR_W  = 32;

  logic             clock = 1'b0;
  logic             clear, ir_load, gra, grb, grc, rin_en, rout_en, ba_out, seq_start, seq_adv;
  logic [IR_W-1:0]  ir_in;
  logic [IR_W-1:0]  ir_q, c_sext;
  logic [RBITS-1:0] sel_idx;
  logic             sel_conflict, r0_zero, seq_busy, seq_done;
  logic [NREGS-1:0] rin, rout;
  logic [RBITS:0]   seq_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  sel_encode_seq dut (
    .clock(clock), .clear(clear), .ir_load(ir_load), .ir_in(ir_in),
    .gra(gra), .grb(grb), .grc(grc), .rin_en(rin_en), .rout_en(rout_en),
    .ba_out(ba_out), .seq_start(seq_start), .seq_adv(seq_adv),
    .ir_q(ir_q), .c_sext(c_sext), .sel_idx(sel_idx), .sel_conflict(sel_conflict),
    .rin(rin), .rout(rout), .r0_zero(r0_zero), .seq_busy(seq_busy),
    .seq_done(seq_done), .seq_count(seq_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; ir_load = 0; ir_in = '0; gra = 0; grb = 0; grc = 0;
    rin_en = 0; rout_en = 0; ba_out = 0; seq_start = 0; seq_adv = 0;
  endtask

  task automatic load_ir(input logic [IR_W-1:0] v);
    ir_in = v; ir_load = 1;
    tick();
    ir_load = 0;
  endtask

  task automatic test_reset();
    clear = 1; ir_load = 1; ir_in = $urandom; seq_start = 1; seq_adv = 1;
    tick();
    tick();
    idle_inputs();
    #1;
    n_checks++; if (ir_q !== '0) begin n_errors++; $display("FAIL reset_ir_q got=%h want=0", ir_q); end
    n_checks++; if (c_sext !== '0) begin n_errors++; $display("FAIL reset_c_sext got=%h want=0", c_sext); end
    n_checks++; if ({rin, rout} !== '0) begin n_errors++; $display("FAIL reset_rin_rout got=%h want=0", {rin, rout}); end
    n_checks++; if ({sel_idx, sel_conflict, r0_zero, seq_busy, seq_done, seq_count} !== '0) begin
      n_errors++; $display("FAIL reset_misc got=%h want=0", {sel_idx, sel_conflict, r0_zero, seq_busy, seq_done, seq_count});
    end
  endtask

  task automatic test_decode_ra();
    load_ir(32'h0280_0000);
    gra = 1; rin_en = 1;
    #1;
    n_checks++; if (sel_idx !== 4'd5) begin n_errors++; $display("FAIL ra_sel got=%0d want=5", sel_idx); end
    n_checks++; if (rin !== 16'h0020) begin n_errors++; $display("FAIL ra_rin got=%h want=0020", rin); end
    n_checks++; if (rout !== 16'h0000) begin n_errors++; $display("FAIL ra_rout got=%h want=0000", rout); end
    n_checks++; if (sel_conflict !== 1'b0) begin n_errors++; $display("FAIL ra_conflict got=%b want=0", sel_conflict); end
    idle_inputs();
  endtask

  task automatic test_priority();
    load_ir(32'h0298_0000);
    gra = 1; grb = 1; rout_en = 1;
    #1;
    n_checks++; if (sel_idx !== 4'd5) begin n_errors++; $display("FAIL prio_sel got=%0d want=5", sel_idx); end
    n_checks++; if (rout !== 16'h0020) begin n_errors++; $display("FAIL prio_rout got=%h want=0020", rout); end
    n_checks++; if (sel_conflict !== 1'b1) begin n_errors++; $display("FAIL prio_conflict got=%b want=1", sel_conflict); end
    gra = 0;
    #1;
    n_checks++; if (sel_idx !== 4'd3) begin n_errors++; $display("FAIL rb_sel got=%0d want=3", sel_idx); end
    n_checks++; if (rout !== 16'h0008) begin n_errors++; $display("FAIL rb_rout got=%h want=0008", rout); end
    n_checks++; if (sel_conflict !== 1'b0) begin n_errors++; $display("FAIL rb_conflict got=%b want=0", sel_conflict); end
    idle_inputs();
  endtask

  task automatic test_csext_r0();
    load_ir(32'h0004_0000);
    #1;
    n_checks++; if (c_sext !== 32'hFFFC_0000) begin n_errors++; $display("FAIL csext_neg got=%h want=fffc0000", c_sext); end
    load_ir(32'h0003_FFFF);
    #1;
    n_checks++; if (c_sext !== 32'h0003_FFFF) begin n_errors++; $display("FAIL csext_pos got=%h want=0003ffff", c_sext); end
    gra = 1; ba_out = 1;
    #1;
    n_checks++; if (rout !== 16'h0000) begin n_errors++; $display("FAIL r0_rout got=%h want=0000", rout); end
    n_checks++; if (r0_zero !== 1'b1) begin n_errors++; $display("FAIL r0_zero got=%b want=1", r0_zero); end
    idle_inputs();
  endtask

  task automatic test_random_normal();
    for (int it = 0; it < 150; it++) begin
      logic [IR_W-1:0] ir;
      longint c, e_csext;
      int ra, rb, rc, e_sel, nsel;
      logic [NREGS-1:0] oh, e_rin, e_rout;
      logic e_conf, e_r0;
      ir = $urandom;
      load_ir(ir);
      {gra, grb, grc, rin_en, rout_en, ba_out} = 6'($urandom);
      #1;
      ra = (ir >> 23) % NREGS; rb = (ir >> 19) % NREGS; rc = (ir >> 15) % NREGS;
      nsel = int'(gra) + int'(grb) + int'(grc);
      e_sel = gra ? ra : grb ? rb : grc ? rc : 0;
      e_conf = (nsel >= 2);
      oh = (nsel > 0) ? NREGS'(1 << e_sel) : '0;
      e_rin = rin_en ? oh : '0;
      e_rout = (rout_en || ba_out) ? oh : '0;
      e_r0 = ba_out && (nsel > 0) && (e_sel == 0);
      if (e_r0) e_rout[0] = 1'b0;
      c = longint'(ir) % (1 << 19);
      e_csext = (c >= (1 << 18)) ? c + (64'h1_0000_0000 - (1 << 19)) : c;
      n_checks++; if (sel_idx !== RBITS'(e_sel)) begin n_errors++; $display("FAIL rnd_sel ir=%h got=%0d want=%0d", ir, sel_idx, e_sel); end
      n_checks++; if (sel_conflict !== e_conf) begin n_errors++; $display("FAIL rnd_conflict got=%b want=%b", sel_conflict, e_conf); end
      n_checks++; if (rin !== e_rin) begin n_errors++; $display("FAIL rnd_rin ir=%h got=%h want=%h", ir, rin, e_rin); end
      n_checks++; if (rout !== e_rout) begin n_errors++; $display("FAIL rnd_rout ir=%h got=%h want=%h", ir, rout, e_rout); end
      n_checks++; if (r0_zero !== e_r0) begin n_errors++; $display("FAIL rnd_r0 got=%b want=%b", r0_zero, e_r0); end
      n_checks++; if (c_sext !== IR_W'(e_csext)) begin n_errors++; $display("FAIL rnd_csext got=%h want=%h", c_sext, IR_W'(e_csext)); end
      idle_inputs();
    end
  endtask

  task automatic test_seq_basic();
    logic [NREGS-1:0] exp_rout [3] = '{16'h0001, 16'h0004, 16'h8000};
    load_ir(32'h0000_8005);
    seq_start = 1; rout_en = 1; seq_adv = 1;
    tick();
    seq_start = 0;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rout !== exp_rout[k] || seq_busy !== 1'b1) begin
        n_errors++; $display("FAIL seq_step%0d rout got=%h want=%h busy=%b", k, rout, exp_rout[k], seq_busy);
      end
      tick();
    end
    n_checks++; if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin n_errors++; $display("FAIL seq_done_pulse got=%b want=1", seq_done); end
    n_checks++; if (seq_count !== 5'd3) begin n_errors++; $display("FAIL seq_count got=%0d want=3", seq_count); end
    tick();
    n_checks++; if (seq_done !== 1'b0 || seq_busy !== 1'b0) begin n_errors++; $display("FAIL seq_done_once got=%b want=0", seq_done); end
    n_checks++; if (seq_count !== 5'd3) begin n_errors++; $display("FAIL seq_count_hold got=%0d want=3", seq_count); end
    idle_inputs();
  endtask

  task automatic test_seq_stall();
    load_ir(32'h0000_8005);
    seq_start = 1; rout_en = 1; seq_adv = 1;
    tick();
    seq_start = 0;
    tick();
    seq_adv = 0; ir_load = 1; ir_in = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (rout !== 16'h0004) begin n_errors++; $display("FAIL stall_hold%0d got=%h want=0004", k, rout); end
      if (k == 2) seq_adv = 1;
      tick();
    end
    ir_load = 0;
    n_checks++; if (rout !== 16'h8000) begin n_errors++; $display("FAIL stall_resume got=%h want=8000", rout); end
    n_checks++; if (ir_q !== 32'h0000_8005) begin n_errors++; $display("FAIL stall_ir_q got=%h want=00008005", ir_q); end
    tick();
    tick();
    idle_inputs();
  endtask

  task automatic test_seq_empty_and_clear();
    load_ir(32'h0000_0000);
    seq_start = 1;
    tick();
    seq_start = 0;
    n_checks++; if (seq_busy !== 1'b0 || seq_done !== 1'b1 || seq_count !== '0) begin
      n_errors++; $display("FAIL empty_seq busy=%b done=%b count=%0d want 0/1/0", seq_busy, seq_done, seq_count);
    end
    tick();
    n_checks++; if (seq_done !== 1'b0) begin n_errors++; $display("FAIL empty_done_once got=%b want=0", seq_done); end
    load_ir(32'h0280_00F0);
    seq_start = 1; seq_adv = 1; rout_en = 1; rin_en = 1;
    tick();
    seq_start = 0;
    tick();
    clear = 1;
    tick();
    idle_inputs();
    #1;
    n_checks++; if ({ir_q, rin, rout, sel_idx, sel_conflict, r0_zero, seq_busy, seq_done, seq_count} !== '0) begin
      n_errors++; $display("FAIL clear_mid busy=%b count=%0d ir_q=%h rout=%h want all 0", seq_busy, seq_count, ir_q, rout);
    end
  endtask

  task automatic test_random_seq();
    for (int run = 0; run < 12; run++) begin
      logic [IR_W-1:0] old_ir, new_ir;
      int q[$];
      int cnt, budget;
      old_ir = $urandom;
      if (run == 0) old_ir[NREGS-1:0] = '1;
      load_ir(old_ir);
      for (int b = 0; b < NREGS; b++) if (old_ir[b]) q.push_back(b);
      new_ir = $urandom;
      seq_start = 1; ir_load = 1; ir_in = new_ir; rin_en = 1; rout_en = 1;
      tick();
      seq_start = 0; ir_load = 0;
      cnt = 0; budget = 200;
      while (q.size() > 0 && budget > 0) begin
        {gra, grb, grc, ba_out, ir_load} = 5'($urandom);
        ir_in = $urandom;
        #1;
        n_checks++; if (sel_idx !== RBITS'(q[0]) || rout !== NREGS'(1 << q[0]) || rin !== NREGS'(1 << q[0])) begin
          n_errors++; $display("FAIL rseq_step sel=%0d want=%0d rout=%h rin=%h", sel_idx, q[0], rout, rin);
        end
        n_checks++; if (seq_busy !== 1'b1 || sel_conflict !== 1'b0 || r0_zero !== 1'b0) begin
          n_errors++; $display("FAIL rseq_flags busy=%b conf=%b r0=%b want 1/0/0", seq_busy, sel_conflict, r0_zero);
        end
        seq_adv = 1'($urandom);
        tick();
        if (seq_adv) begin void'(q.pop_front()); cnt++; end
        budget--;
      end
      if (budget == 0) begin n_errors++; n_checks++; $display("FAIL rseq_timeout remaining=%0d", q.size()); end
      idle_inputs();
      #1;
      n_checks++; if (seq_done !== 1'b1 || seq_count !== 5'(cnt)) begin
        n_errors++; $display("FAIL rseq_done done=%b count=%0d want 1/%0d", seq_done, seq_count, cnt);
      end
      n_checks++; if (ir_q !== new_ir) begin n_errors++; $display("FAIL rseq_ir_q got=%h want=%h", ir_q, new_ir); end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_decode_ra();
    test_priority();
    test_csext_r0();
    test_random_normal();
    test_seq_basic();
    test_seq_stall();
    test_seq_empty_and_clear();
    test_random_seq();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
